// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FWFT stream arbiter and its helpers.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_t;

  // Source tag lands in the top nibble of the merged data word
  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 28;

  // Index width never drops below one bit so a single-channel build still has a port
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Burst counter must be able to hold MAX_BURST itself
  function automatic int cntWidth(input int maxBurst);
    return $clog2(maxBurst + 1);
  endfunction

  // Widths for the default build (N=4, MAX_BURST=16)
  localparam int IW = idxWidth(4);
  localparam int CW = cntWidth(16);

endpackage

// File: rtl/fifo_stream_arbiter_rr_pick.sv
// Combinational round-robin search: first request strictly after i_last, modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Walk from the furthest candidate back towards last+1 so the nearest request wins
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (i_req[(int'(i_last) + k) % N]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'((int'(i_last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_stream_arbiter.sv
// Round-robin merge of N FWFT producer streams into one FWFT consumer port,
// with bounded bursts, optional source tagging and a sticky read-underflow flag.
module fifo_stream_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 16,
  parameter bit TAG_EN    = 1'b1,
  localparam int IDX_W    = idxWidth(N)
) (
  input  logic               BUS_CLK,
  input  logic               BUS_RST_N,
  input  logic [N-1:0]       CH_ENABLE,
  input  logic [N-1:0]       CH_EMPTY,
  input  logic [N*32-1:0]    CH_DATA,
  output logic [N-1:0]       CH_READ_NEXT,
  input  logic               FIFO_READ_NEXT_IN,
  output logic               FIFO_EMPTY_OUT,
  output logic [31:0]        FIFO_DATA_OUT,
  output logic               GRANT_VALID,
  output logic [IDX_W-1:0]   GRANT_IDX,
  output logic               READ_ERROR,
  input  logic               ERROR_CLR
);

  localparam int CNT_W = cntWidth(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(N - 1);

  arbState_t          r_state;
  logic               r_grantValid;
  logic [IDX_W-1:0]   r_grantIdx;
  logic [IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_count;
  logic               r_readError;

  logic [N-1:0]       w_request;
  logic               w_found;
  logic [IDX_W-1:0]   w_pickIdx;
  logic               w_chEmpty;
  logic               w_chEnable;
  logic               w_fifoEmpty;
  logic               w_accept;
  logic [31:0]        w_data;
  logic [N-1:0]       w_readNext;

  assign w_request = CH_ENABLE & ~CH_EMPTY;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rrPick (
    .i_req   (w_request),
    .i_last  (r_last),
    .o_found (w_found),
    .o_idx   (w_pickIdx)
  );

  // Steer the granted channel onto the merged port straight from the registered grant
  always_comb begin
    w_chEmpty   = CH_EMPTY[r_grantIdx];
    w_chEnable  = CH_ENABLE[r_grantIdx];
    w_fifoEmpty = ~r_grantValid | w_chEmpty | ~w_chEnable;
    w_accept    = FIFO_READ_NEXT_IN & ~w_fifoEmpty;
    w_data      = CH_DATA[32*int'(r_grantIdx) +: 32];
    if (TAG_EN) begin
      w_data[TAG_MSB:TAG_LSB] = 4'(r_grantIdx);
    end
    w_readNext             = '0;
    w_readNext[r_grantIdx] = w_accept;
  end

  // Grant FSM: search in IDLE, hold the grant in GRANT until burst end, drain or disable
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_state      <= IDLE;
      r_grantValid <= 1'b0;
      r_grantIdx   <= '0;
      r_last       <= LAST_CH;
      r_count      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grantIdx   <= w_pickIdx;
            r_grantValid <= 1'b1;
            r_count      <= '0;
            r_state      <= GRANT;
          end
        end
        GRANT: begin
          if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
          end
          if (!w_chEnable || (w_accept && (r_count == LAST_BEAT)) || (w_chEmpty && !w_accept)) begin
            r_last       <= r_grantIdx;
            r_grantValid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_grantValid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  // Sticky underflow flag; a fresh violation beats a clear in the same cycle
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_readError <= 1'b0;
    end else if (FIFO_READ_NEXT_IN && w_fifoEmpty) begin
      r_readError <= 1'b1;
    end else if (ERROR_CLR) begin
      r_readError <= 1'b0;
    end
  end

  assign CH_READ_NEXT   = w_readNext;
  assign FIFO_EMPTY_OUT = w_fifoEmpty;
  assign FIFO_DATA_OUT  = w_data;
  assign GRANT_VALID    = r_grantValid;
  assign GRANT_IDX      = r_grantIdx;
  assign READ_ERROR     = r_readError;

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// Directed bench for fifo_stream_arbiter (N=4, MAX_BURST=4, TAG_EN=1) with
// simple FWFT producer queues feeding each channel.
module tb_fifo_stream_arbiter;

  logic         BUS_CLK = 1'b0;
  logic         BUS_RST_N;
  logic [3:0]   CH_ENABLE;
  logic [3:0]   CH_EMPTY;
  logic [127:0] CH_DATA;
  logic [3:0]   CH_READ_NEXT;
  logic         FIFO_READ_NEXT_IN;
  logic         FIFO_EMPTY_OUT;
  logic [31:0]  FIFO_DATA_OUT;
  logic         GRANT_VALID;
  logic [1:0]   GRANT_IDX;
  logic         READ_ERROR;
  logic         ERROR_CLR;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [31:0] chMem [4][64];
  logic [5:0]  head [4] = '{default: '0};
  logic [5:0]  tail [4] = '{default: '0};
  int          popCount [4] = '{default: 0};
  int          popStart;

  fifo_stream_arbiter #(
    .N         (4),
    .MAX_BURST (4),
    .TAG_EN    (1'b1)
  ) dut (
    .BUS_CLK           (BUS_CLK),
    .BUS_RST_N         (BUS_RST_N),
    .CH_ENABLE         (CH_ENABLE),
    .CH_EMPTY          (CH_EMPTY),
    .CH_DATA           (CH_DATA),
    .CH_READ_NEXT      (CH_READ_NEXT),
    .FIFO_READ_NEXT_IN (FIFO_READ_NEXT_IN),
    .FIFO_EMPTY_OUT    (FIFO_EMPTY_OUT),
    .FIFO_DATA_OUT     (FIFO_DATA_OUT),
    .GRANT_VALID       (GRANT_VALID),
    .GRANT_IDX         (GRANT_IDX),
    .READ_ERROR        (READ_ERROR),
    .ERROR_CLR         (ERROR_CLR)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  // Producer queues present their head word first-word-fall-through style
  always_comb begin
    CH_EMPTY = '0;
    CH_DATA  = '0;
    for (int i = 0; i < 4; i++) begin
      CH_EMPTY[i]          = (head[i] == tail[i]);
      CH_DATA[32*i +: 32]  = chMem[i][head[i]];
    end
  end

  // Producer queues advance on the pop strobe from the arbiter
  always @(posedge BUS_CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (CH_READ_NEXT[i]) begin
        head[i]     <= head[i] + 6'd1;
        popCount[i] <= popCount[i] + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic [3:0] en, input logic clr);
    @(posedge BUS_CLK);
    #1;
    FIFO_READ_NEXT_IN = rn;
    CH_ENABLE         = en;
    ERROR_CLR         = clr;
  endtask

  task automatic pushWord(input int ch, input logic [31:0] word);
    chMem[ch][tail[ch]] = word;
    tail[ch]            = tail[ch] + 6'd1;
  endtask

  task automatic checkCycle(input string tag, input logic expGv, input logic expEmpty,
                            input logic [1:0] expIdx, input logic [31:0] expData, input logic [3:0] expRn);
    @(negedge BUS_CLK);
    checkOutput({tag, "/gv"}, 32'(GRANT_VALID), 32'(expGv));
    checkOutput({tag, "/empty"}, 32'(FIFO_EMPTY_OUT), 32'(expEmpty));
    if (expGv) checkOutput({tag, "/idx"}, 32'(GRANT_IDX), 32'(expIdx));
    if (!expEmpty) checkOutput({tag, "/data"}, FIFO_DATA_OUT, expData);
    checkOutput({tag, "/rdnext"}, 32'(CH_READ_NEXT), 32'(expRn));
  endtask

  initial begin
    BUS_RST_N         = 1'b0;
    CH_ENABLE         = 4'hF;
    FIFO_READ_NEXT_IN = 1'b0;
    ERROR_CLR         = 1'b0;
    repeat (2) @(posedge BUS_CLK);
    #1 BUS_RST_N = 1'b1;

    // Reset state and reads against an idle arbiter
    checkCycle("rst", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    checkOutput("rst/idxreg", 32'(GRANT_IDX), 32'h0);
    checkOutput("rst/err", 32'(READ_ERROR), 32'h0);
    applyStimulus(1'b1, 4'hF, 1'b0); checkCycle("idleRd1", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    checkOutput("idleRd1/err", 32'(READ_ERROR), 32'h0);
    applyStimulus(1'b1, 4'hF, 1'b0); checkCycle("idleRd2", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    checkOutput("idleRd2/err", 32'(READ_ERROR), 32'h1);
    applyStimulus(1'b1, 4'hF, 1'b0); @(negedge BUS_CLK);
    checkOutput("idleRd3/err", 32'(READ_ERROR), 32'h1);
    applyStimulus(1'b0, 4'hF, 1'b1); @(negedge BUS_CLK);
    checkOutput("clr/errHeld", 32'(READ_ERROR), 32'h1);
    applyStimulus(1'b0, 4'hF, 1'b0); @(negedge BUS_CLK);
    checkOutput("clr/errGone", 32'(READ_ERROR), 32'h0);
    applyStimulus(1'b1, 4'hF, 1'b1); @(negedge BUS_CLK);
    applyStimulus(1'b0, 4'hF, 1'b0); @(negedge BUS_CLK);
    checkOutput("setWins/err", 32'(READ_ERROR), 32'h1);
    applyStimulus(1'b0, 4'hF, 1'b1);
    applyStimulus(1'b0, 4'hF, 1'b0); @(negedge BUS_CLK);
    checkOutput("clr2/err", 32'(READ_ERROR), 32'h0);

    // Single channel: ch2 with five words, burst of four then re-grant for the fifth
    applyStimulus(1'b0, 4'hF, 1'b0);
    for (int k = 0; k < 5; k++) pushWord(2, 32'hA0 + k);
    checkCycle("ch2/latency", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 4'hF, 1'b0);
      checkCycle($sformatf("ch2/w%0d", k), 1'b1, 1'b0, 2'd2, 32'h200000A0 + k, 4'b0100);
    end
    applyStimulus(1'b1, 4'hF, 1'b0); checkCycle("ch2/gap", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    applyStimulus(1'b1, 4'hF, 1'b0); checkCycle("ch2/w4", 1'b1, 1'b0, 2'd2, 32'h200000A4, 4'b0100);
    applyStimulus(1'b1, 4'hF, 1'b0); checkCycle("ch2/drained", 1'b1, 1'b1, 2'd2, 32'h0, 4'h0);
    applyStimulus(1'b0, 4'hF, 1'b0); checkCycle("ch2/released", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    checkOutput("ch2/err", 32'(READ_ERROR), 32'h1);
    applyStimulus(1'b0, 4'hF, 1'b1);
    applyStimulus(1'b0, 4'hF, 1'b0);

    // Fairness: ch0 and ch3 both loaded, last grant was ch2 so ch3 goes first
    applyStimulus(1'b0, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) pushWord(0, 32'hB00 + k);
    for (int k = 0; k < 8; k++) pushWord(3, 32'hC00 + k);
    checkCycle("fair/start", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    popStart = popCount[0] + popCount[3];
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(1'b1, 4'hF, 1'b0);
      if (k <= 4)
        checkCycle($sformatf("fair%0d", k), 1'b1, 1'b0, 2'd3, 32'h30000C00 + (k - 1), 4'b1000);
      else if (k == 5 || k == 10)
        checkCycle($sformatf("fair%0d", k), 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
      else if (k <= 9)
        checkCycle($sformatf("fair%0d", k), 1'b1, 1'b0, 2'd0, 32'h00000B00 + (k - 6), 4'b0001);
      else
        checkCycle($sformatf("fair%0d", k), 1'b1, 1'b0, 2'd3, 32'h30000C04 + (k - 11), 4'b1000);
      if (k == 11) checkOutput("fair/wordsIn10", 32'(popCount[0] + popCount[3] - popStart), 32'd8);
    end
    applyStimulus(1'b0, 4'hF, 1'b0); checkCycle("fair/end", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    applyStimulus(1'b0, 4'hF, 1'b1);
    applyStimulus(1'b0, 4'hF, 1'b0); @(negedge BUS_CLK);
    checkOutput("fair/errClr", 32'(READ_ERROR), 32'h0);

    // Wrap-around from last=3 plus backpressure on the ch1 grant
    applyStimulus(1'b0, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) pushWord(1, 32'hD0 + k);
    pushWord(2, 32'hE0);
    checkCycle("bp/start", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    popStart = popCount[1];
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(k % 2 == 1, 4'hF, 1'b0);
      checkCycle($sformatf("bp%0d", k), 1'b1, 1'b0, 2'd1, 32'h100000D0 + (k / 2),
                 (k % 2 == 1) ? 4'b0010 : 4'b0000);
    end
    applyStimulus(1'b0, 4'hF, 1'b0); checkCycle("bp8", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    applyStimulus(1'b1, 4'hF, 1'b0); checkCycle("bp9", 1'b1, 1'b0, 2'd2, 32'h200000E0, 4'b0100);
    applyStimulus(1'b0, 4'hF, 1'b0); checkCycle("bp10", 1'b1, 1'b1, 2'd2, 32'h0, 4'h0);
    applyStimulus(1'b0, 4'hF, 1'b0); checkCycle("bp11", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    checkOutput("bp/ch1Pops", 32'(popCount[1] - popStart), 32'd4);
    checkOutput("bp/err", 32'(READ_ERROR), 32'h0);

    // Disable ch1 mid-burst; ch3 takes over
    applyStimulus(1'b0, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) pushWord(1, 32'hF0 + k);
    checkCycle("dis/start", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    applyStimulus(1'b1, 4'hF, 1'b0);
    pushWord(3, 32'h77);
    checkCycle("dis/w0", 1'b1, 1'b0, 2'd1, 32'h100000F0, 4'b0010);
    applyStimulus(1'b1, 4'hF, 1'b0);   checkCycle("dis/w1", 1'b1, 1'b0, 2'd1, 32'h100000F1, 4'b0010);
    applyStimulus(1'b0, 4'b1101, 1'b0); checkCycle("dis/off", 1'b1, 1'b1, 2'd1, 32'h0, 4'h0);
    applyStimulus(1'b0, 4'b1101, 1'b0); checkCycle("dis/rel", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    applyStimulus(1'b1, 4'b1101, 1'b0); checkCycle("dis/ch3", 1'b1, 1'b0, 2'd3, 32'h30000077, 4'b1000);
    applyStimulus(1'b0, 4'b1101, 1'b0); checkCycle("dis/ch3dry", 1'b1, 1'b1, 2'd3, 32'h0, 4'h0);

    // Reset mid-burst: grant drops at once and the next search starts at ch0
    applyStimulus(1'b0, 4'hF, 1'b0); checkCycle("mrst/idle", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    applyStimulus(1'b1, 4'hF, 1'b0); checkCycle("mrst/w0", 1'b1, 1'b0, 2'd1, 32'h100000F2, 4'b0010);
    applyStimulus(1'b0, 4'hF, 1'b0);
    #1 BUS_RST_N = 1'b0;
    #1;
    checkOutput("mrst/gv", 32'(GRANT_VALID), 32'h0);
    checkOutput("mrst/empty", 32'(FIFO_EMPTY_OUT), 32'h1);
    checkOutput("mrst/rdnext", 32'(CH_READ_NEXT), 32'h0);
    #1 BUS_RST_N = 1'b1;
    pushWord(0, 32'h55);
    applyStimulus(1'b1, 4'hF, 1'b0); checkCycle("mrst/ch0", 1'b1, 1'b0, 2'd0, 32'h00000055, 4'b0001);
    applyStimulus(1'b0, 4'hF, 1'b0); checkCycle("mrst/ch0dry", 1'b1, 1'b1, 2'd0, 32'h0, 4'h0);
    applyStimulus(1'b0, 4'hF, 1'b0); checkCycle("mrst/idle2", 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
    applyStimulus(1'b0, 4'hF, 1'b0); checkCycle("mrst/noReplay", 1'b1, 1'b0, 2'd1, 32'h100000F3, 4'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
